vend_fsm_param: RTL and testbench
=================================

# vend_fsm_param

Parametrised vending-machine controller, the next generation of the fixed 15 Rs coin FSM. It accumulates 5 Rs and 10 Rs coins up to a configurable price and dispenses one item. It returns any change as a train of 5 Rs pulses, and supports customer cancel/refund and invalid-coin rejection. It also tracks product stock with restock and sold-out indication, and sits between the coin acceptor front end and the dispense/payout actuators.

## Interface
Parameters:
- PRICE_UNITS, 3: item price in 5 Rs units; legal range 1 to 2^CREDIT_W-2.
- CREDIT_W, 4: credit register width in 5 Rs units; must satisfy PRICE_UNITS+1 < 2^CREDIT_W.
- STOCK_INIT, 8: stock count loaded at reset and on restock.
- STOCK_W, 4: stock counter width; STOCK_INIT < 2^STOCK_W.

Ports:
- clk  input  1  single clock, all state changes on rising edge.
- reset  input  1  asynchronous, active-high; clears the FSM immediately.
- coin  input  2  00 = none, 01 = 5 Rs, 10 = 10 Rs, 11 = invalid; sampled every edge.
- cancel  input  1  customer abort; refund accumulated credit.
- restock  input  1  reload stock to STOCK_INIT; honoured only in IDLE.
- dispense  output  1  item release, high for exactly one cycle per sale.
- return5  output  1  one 5 Rs payout per high cycle.
- reject  output  1  registered one-cycle pulse: the coin sampled at the previous edge was not accepted.
- credit  output  CREDIT_W  current credit, or remaining change/refund, in 5 Rs units.
- sold_out  output  1  high while stock == 0.
- busy  output  1  high in DISP or RETURN.
- current_state  output  3  IDLE = 000, COLLECT = 001, DISP = 010, RETURN = 011.

## Operation
- Coin value: 01 adds 1 unit, 10 adds 2 units. Credit arithmetic is unsigned at CREDIT_W; it never exceeds PRICE_UNITS+1 by construction.
- IDLE, with credit == 0:
  - A valid coin with stock > 0 goes to COLLECT, or straight to DISP if the coin value is ≥ PRICE_UNITS.
  - Coin 11, or any coin while stock == 0, sets reject; the state stays IDLE.
  - restock loads stock to STOCK_INIT.
  - cancel in IDLE has no effect.
- COLLECT:
  - A valid coin computes sum = credit + value.
  - If sum ≥ PRICE_UNITS: next state DISP and credit <= sum − PRICE_UNITS (the change owed).
  - Otherwise credit <= sum and the state stays COLLECT.
  - Coin 11 sets reject; credit is unchanged.
- cancel in COLLECT has priority over a same-cycle coin. That coin is rejected (reject set) and the state goes to RETURN holding the pre-coin credit.
- DISP lasts one cycle: dispense = 1 and stock decrements by 1. Next state is RETURN if credit > 0, else IDLE.
- RETURN: return5 = 1 every cycle and credit decrements by 1 per cycle. When credit == 1, this is the final pulse and the next state is IDLE with credit 0.
- Coins in DISP or RETURN are rejected (reject set). cancel and restock are ignored in these states.
- dispense, return5, busy and sold_out are decoded from registered state. reject is a flop.
- Encodings 100 to 111 are illegal; the FSM recovers to IDLE with credit cleared on the next edge.

## Timing
- Reset values: current_state = IDLE, credit = 0, stock = STOCK_INIT, dispense = 0, return5 = 0, reject = 0, busy = 0, sold_out = (STOCK_INIT == 0).
- The coin reaching the price at edge N gives dispense high for cycle N→N+1. Change pulses follow on the next k consecutive cycles, where k is the change owed.
- A cancel sampled at edge N gives the first return5 in cycle N→N+1, then k consecutive pulses.
- reject is high for the single cycle following the edge that sampled the rejected coin.
- Sale-to-IDLE latency = 1 + change cycles. The machine is ready for a new coin at the first edge in IDLE.
- Reset asserted mid-DISP or mid-RETURN aborts the sale; the remaining change is forfeited (no pulses after reset).
- A stock decrement to 0 raises sold_out in the cycle after DISP.

## Test plan
Defaults apply (PRICE_UNITS = 3) unless stated otherwise.
- Exact price: 01, 10 on consecutive edges -> one dispense pulse, no return5, credit 0, back to IDLE; stock 8→7.
- Overpay: 10, 10 -> dispense, then exactly one return5 cycle, credit 1→0, IDLE two cycles after DISP.
- Cancel with a same-cycle coin: 10, then cancel + 01 together -> reject pulse, two return5 cycles, no dispense, stock unchanged.
- Invalid and busy coins: 11 in IDLE, and 01 during RETURN -> reject pulse each time, credit/state unaffected.
- Stock exhaustion with STOCK_INIT = 1: complete one sale -> sold_out = 1, next 01 rejected. restock in IDLE -> sold_out = 0 and 01 accepted.
- Reset mid-change with PRICE_UNITS = 1 and CREDIT_W = 3: insert 10 -> DISP, credit 1. Assert reset during DISP -> no return5, all outputs at reset values.

Source files
------------

// File: rtl/vend_fsm_param.sv
// Parametrised vending controller: collects 5/10 Rs coins up to PRICE_UNITS, dispenses one item,
// pays change or refunds as 5 Rs pulses, rejects bad/late coins and tracks stock with restock.
module vend_fsm_param #(
  parameter int unsigned PRICE_UNITS = 3,
  parameter int unsigned CREDIT_W    = 4,
  parameter int unsigned STOCK_INIT  = 8,
  parameter int unsigned STOCK_W     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          coin,
  input  logic                cancel,
  input  logic                restock,
  output logic                dispense,
  output logic                return5,
  output logic                reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                sold_out,
  output logic                busy,
  output logic [2:0]          current_state
);

  localparam logic [CREDIT_W-1:0] PRICE     = CREDIT_W'(PRICE_UNITS);
  localparam logic [STOCK_W-1:0]  STOCK_RST = STOCK_W'(STOCK_INIT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_COLLECT = 3'b001,
    S_DISP    = 3'b010,
    S_RETURN  = 3'b011
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CREDIT_W-1:0] credit_nxt;
  logic [STOCK_W-1:0]  stock;
  logic [STOCK_W-1:0]  stock_nxt;
  logic                reject_nxt;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] sum;
  logic                coin_ok;
  logic                coin_any;

  // State, credit, stock and reject registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      credit <= '0;
      stock  <= STOCK_RST;
      reject <= 1'b0;
    end else begin
      state  <= state_nxt;
      credit <= credit_nxt;
      stock  <= stock_nxt;
      reject <= reject_nxt;
    end
  end

  // Next-state, credit and stock update
  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    stock_nxt  = stock;
    reject_nxt = 1'b0;
    coin_ok    = (coin == 2'b01) || (coin == 2'b10);
    coin_any   = (coin != 2'b00);
    case (coin)
      2'b01:   coin_val = CREDIT_W'(1);
      2'b10:   coin_val = CREDIT_W'(2);
      default: coin_val = '0;
    endcase
    sum = credit + coin_val;

    case (state)
      S_IDLE: begin
        credit_nxt = '0;
        if (restock) stock_nxt = STOCK_RST;
        if (coin_ok && (stock != '0)) begin
          if (coin_val >= PRICE) begin
            state_nxt  = S_DISP;
            credit_nxt = coin_val - PRICE;
          end else begin
            state_nxt  = S_COLLECT;
            credit_nxt = coin_val;
          end
        end else if (coin_any) begin
          reject_nxt = 1'b1;
        end
      end
      S_COLLECT: begin
        // A same-cycle coin loses to cancel and is bounced
        if (cancel) begin
          state_nxt  = S_RETURN;
          reject_nxt = coin_any;
        end else if (coin_ok) begin
          if (sum >= PRICE) begin
            state_nxt  = S_DISP;
            credit_nxt = sum - PRICE;
          end else begin
            credit_nxt = sum;
          end
        end else if (coin_any) begin
          reject_nxt = 1'b1;
        end
      end
      S_DISP: begin
        reject_nxt = coin_any;
        stock_nxt  = stock - STOCK_W'(1);
        state_nxt  = (credit != '0) ? S_RETURN : S_IDLE;
      end
      S_RETURN: begin
        reject_nxt = coin_any;
        credit_nxt = credit - CREDIT_W'(1);
        if (credit <= CREDIT_W'(1)) begin
          state_nxt  = S_IDLE;
          credit_nxt = '0;
        end
      end
      default: begin
        state_nxt  = S_IDLE;
        credit_nxt = '0;
      end
    endcase
  end

  // Actuator and status decode from registered state
  always_comb begin
    dispense      = (state == S_DISP);
    return5       = (state == S_RETURN);
    busy          = (state == S_DISP) || (state == S_RETURN);
    sold_out      = (stock == '0);
    current_state = state;
  end

endmodule

// File: tb/tb_vend_fsm_param.sv
// Bench for vend_fsm_param: three configurations checked every cycle against a transaction-level
// model (collected credit, pending dispense, change owed), plus directed literal checks.
module tb_vend_fsm_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst     [3];
  logic [1:0] coin    [3];
  logic       cancel  [3];
  logic       restock [3];
  logic       disp_o  [3];
  logic       ret_o   [3];
  logic       rej_o   [3];
  logic       sold_o  [3];
  logic       busy_o  [3];
  logic [2:0] st_o    [3];
  logic [3:0] cr0;
  logic [3:0] cr1;
  logic [2:0] cr2;

  vend_fsm_param #(.PRICE_UNITS(3), .CREDIT_W(4), .STOCK_INIT(8), .STOCK_W(4)) u0 (
    .clk(clk), .reset(rst[0]), .coin(coin[0]), .cancel(cancel[0]), .restock(restock[0]),
    .dispense(disp_o[0]), .return5(ret_o[0]), .reject(rej_o[0]), .credit(cr0),
    .sold_out(sold_o[0]), .busy(busy_o[0]), .current_state(st_o[0]));

  vend_fsm_param #(.PRICE_UNITS(3), .CREDIT_W(4), .STOCK_INIT(1), .STOCK_W(4)) u1 (
    .clk(clk), .reset(rst[1]), .coin(coin[1]), .cancel(cancel[1]), .restock(restock[1]),
    .dispense(disp_o[1]), .return5(ret_o[1]), .reject(rej_o[1]), .credit(cr1),
    .sold_out(sold_o[1]), .busy(busy_o[1]), .current_state(st_o[1]));

  vend_fsm_param #(.PRICE_UNITS(1), .CREDIT_W(3), .STOCK_INIT(8), .STOCK_W(4)) u2 (
    .clk(clk), .reset(rst[2]), .coin(coin[2]), .cancel(cancel[2]), .restock(restock[2]),
    .dispense(disp_o[2]), .return5(ret_o[2]), .reject(rej_o[2]), .credit(cr2),
    .sold_out(sold_o[2]), .busy(busy_o[2]), .current_state(st_o[2]));

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dut_credit(input int i);
    case (i)
      0:       return int'(cr0);
      1:       return int'(cr1);
      default: return int'(cr2);
    endcase
  endfunction

  // Model: a sale is a dispense cycle followed by 'owed' payout cycles; a refund is just payout.
  int p_price [3] = '{3, 3, 1};
  int p_sinit [3] = '{8, 1, 8};
  int m_acc   [3];
  int m_owed  [3];
  int m_stock [3];
  bit m_disp  [3];
  bit m_rej   [3];

  task automatic model_reset(input int i);
    m_acc[i]   = 0;
    m_owed[i]  = 0;
    m_stock[i] = p_sinit[i];
    m_disp[i]  = 1'b0;
    m_rej[i]   = 1'b0;
  endtask

  task automatic model_step(input int i, input logic [1:0] c, input logic ca, input logic rs);
    bit was_idle;
    int v;
    m_rej[i] = 1'b0;
    if (m_disp[i]) begin
      m_disp[i]  = 1'b0;
      m_stock[i] = m_stock[i] - 1;
      m_rej[i]   = (c != 2'b00);
    end else if (m_owed[i] > 0) begin
      m_owed[i] = m_owed[i] - 1;
      m_rej[i]  = (c != 2'b00);
    end else begin
      was_idle = (m_acc[i] == 0);
      v = (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : 0;
      if (!was_idle && ca) begin
        m_owed[i] = m_acc[i];
        m_acc[i]  = 0;
        m_rej[i]  = (c != 2'b00);
      end else if (c == 2'b11) begin
        m_rej[i] = 1'b1;
      end else if (v > 0) begin
        if (was_idle && m_stock[i] == 0) m_rej[i] = 1'b1;
        else if (m_acc[i] + v >= p_price[i]) begin
          m_disp[i] = 1'b1;
          m_owed[i] = m_acc[i] + v - p_price[i];
          m_acc[i]  = 0;
        end else m_acc[i] = m_acc[i] + v;
      end
      if (was_idle && rs) m_stock[i] = p_sinit[i];
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) model_reset(i);
      else model_step(i, coin[i], cancel[i], restock[i]);
    end
  end

  // Per-cycle comparison of every output of every instance
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int e_st;
      int e_cr;
      bit e_ret;
      e_ret = !m_disp[i] && (m_owed[i] > 0);
      e_st  = m_disp[i] ? 2 : (m_owed[i] > 0) ? 3 : (m_acc[i] > 0) ? 1 : 0;
      e_cr  = (m_disp[i] || m_owed[i] > 0) ? m_owed[i] : m_acc[i];
      chk($sformatf("u%0d.state", i),    int'(st_o[i]),   e_st);
      chk($sformatf("u%0d.credit", i),   dut_credit(i),   e_cr);
      chk($sformatf("u%0d.dispense", i), int'(disp_o[i]), int'(m_disp[i]));
      chk($sformatf("u%0d.return5", i),  int'(ret_o[i]),  int'(e_ret));
      chk($sformatf("u%0d.reject", i),   int'(rej_o[i]),  int'(m_rej[i]));
      chk($sformatf("u%0d.busy", i),     int'(busy_o[i]), int'(m_disp[i] || e_ret));
      chk($sformatf("u%0d.sold_out", i), int'(sold_o[i]), int'(m_stock[i] == 0));
    end
  end

  task automatic cyc(input int i, input logic [1:0] c, input logic ca, input logic rs);
    coin[i]    = c;
    cancel[i]  = ca;
    restock[i] = rs;
    @(posedge clk);
    #1;
    coin[i]    = 2'b00;
    cancel[i]  = 1'b0;
    restock[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; coin[i] = 2'b00; cancel[i] = 1'b0; restock[i] = 1'b0;
      model_reset(i);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    chk("reset.state", int'(st_o[0]), 0);
    chk("reset.credit", int'(cr0), 0);
    chk("reset.sold_out", int'(sold_o[0]), 0);
    chk("reset.sold_out_u1", int'(sold_o[1]), 0);

    // Exact price: 5 then 10
    cyc(0, 2'b01, 1'b0, 1'b0);
    chk("exact.collect_state", int'(st_o[0]), 1);
    chk("exact.collect_credit", int'(cr0), 1);
    cyc(0, 2'b10, 1'b0, 1'b0);
    chk("exact.dispense", int'(disp_o[0]), 1);
    chk("exact.credit", int'(cr0), 0);
    idle(1);
    chk("exact.idle", int'(st_o[0]), 0);
    chk("exact.no_return", int'(ret_o[0]), 0);

    // Overpay: 10 + 10 leaves one unit of change
    cyc(0, 2'b10, 1'b0, 1'b0);
    cyc(0, 2'b10, 1'b0, 1'b0);
    chk("over.dispense", int'(disp_o[0]), 1);
    chk("over.change", int'(cr0), 1);
    idle(1);
    chk("over.return5", int'(ret_o[0]), 1);
    chk("over.ret_state", int'(st_o[0]), 3);
    idle(1);
    chk("over.idle", int'(st_o[0]), 0);
    chk("over.ret_done", int'(ret_o[0]), 0);

    // Cancel with same-cycle coin
    cyc(0, 2'b10, 1'b0, 1'b0);
    cyc(0, 2'b01, 1'b1, 1'b0);
    chk("cancel.reject", int'(rej_o[0]), 1);
    chk("cancel.credit", int'(cr0), 2);
    chk("cancel.return5_1", int'(ret_o[0]), 1);
    idle(1);
    chk("cancel.return5_2", int'(ret_o[0]), 1);
    chk("cancel.credit_1", int'(cr0), 1);
    idle(1);
    chk("cancel.idle", int'(st_o[0]), 0);
    chk("cancel.no_dispense", int'(disp_o[0]), 0);

    // Invalid coin in IDLE, valid coin during RETURN
    cyc(0, 2'b11, 1'b0, 1'b0);
    chk("invalid.reject", int'(rej_o[0]), 1);
    chk("invalid.state", int'(st_o[0]), 0);
    cyc(0, 2'b10, 1'b0, 1'b0);
    cyc(0, 2'b00, 1'b1, 1'b0);
    cyc(0, 2'b01, 1'b0, 1'b0);
    chk("busycoin.reject", int'(rej_o[0]), 1);
    chk("busycoin.credit", int'(cr0), 1);
    chk("busycoin.state", int'(st_o[0]), 3);
    idle(1);
    chk("busycoin.idle", int'(st_o[0]), 0);

    // Stock exhaustion and restock (STOCK_INIT = 1)
    cyc(1, 2'b01, 1'b0, 1'b0);
    cyc(1, 2'b10, 1'b0, 1'b0);
    chk("stock.dispense", int'(disp_o[1]), 1);
    chk("stock.not_yet_sold_out", int'(sold_o[1]), 0);
    idle(1);
    chk("stock.sold_out", int'(sold_o[1]), 1);
    cyc(1, 2'b01, 1'b0, 1'b0);
    chk("stock.reject", int'(rej_o[1]), 1);
    chk("stock.stay_idle", int'(st_o[1]), 0);
    cyc(1, 2'b00, 1'b0, 1'b1);
    chk("restock.sold_out", int'(sold_o[1]), 0);
    cyc(1, 2'b01, 1'b0, 1'b0);
    chk("restock.accept_state", int'(st_o[1]), 1);
    chk("restock.accept_credit", int'(cr1), 1);
    cyc(1, 2'b00, 1'b1, 1'b0);
    idle(1);

    // Reset during DISP forfeits change (PRICE_UNITS = 1, CREDIT_W = 3)
    cyc(2, 2'b10, 1'b0, 1'b0);
    chk("rst.dispense", int'(disp_o[2]), 1);
    chk("rst.change", int'(cr2), 1);
    rst[2] = 1'b1;
    model_reset(2);
    #1;
    chk("rst.state", int'(st_o[2]), 0);
    chk("rst.credit", int'(cr2), 0);
    chk("rst.dispense_low", int'(disp_o[2]), 0);
    chk("rst.return5", int'(ret_o[2]), 0);
    chk("rst.busy", int'(busy_o[2]), 0);
    chk("rst.reject", int'(rej_o[2]), 0);
    chk("rst.sold_out", int'(sold_o[2]), 0);
    @(posedge clk);
    #1;
    rst[2] = 1'b0;
    idle(2);
    chk("rst.no_pulses", int'(ret_o[2]), 0);
    chk("rst.idle", int'(st_o[2]), 0);

    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
